// File: rtl/mips_cache_pkg.sv
// Shared types for the MIPS cache controller.
//
// wb_state_t       : drain status reported by the write buffer on state_out
// wb_entry_t       : one posted-write slot (word address, data, byte lanes)
// DEFAULT_WB_DEPTH : default number of write-buffer entries
package mips_cache_pkg;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_WRITE   = 2'd1,
    WB_PENDING = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wb_entry_t;

  localparam int DEFAULT_WB_DEPTH = 4;

endpackage

// File: rtl/mips_cache_write_buffer.sv
// Posted-write FIFO between the MIPS data port and the Avalon bus.
//
// CPU stores are accepted immediately. A store to a word already buffered
// (and not currently being written to the bus) is combined into that
// entry. Entries drain in FIFO order whenever the controller grants active.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   addr                CPU data address (word compare on [31:2])
//   write_en            CPU store request
//   writedata           store data
//   byteenable          store byte lanes
//   active              controller grants the bus for draining
//   waitrequest         Avalon waitrequest
//   addr_in_wb          addr word matches any valid entry
//   write_addr          head entry address, word aligned
//   write_data          head entry data
//   write_byteenable    head entry byte lanes
//   write_writeenable   Avalon write strobe
//   state_out           drain status (wb_state_t)
//   full, empty         occupancy flags
import mips_cache_pkg::*;

module mips_cache_write_buffer #(
  parameter int DEPTH = DEFAULT_WB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        write_en,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        active,
  input  logic        waitrequest,
  output logic        addr_in_wb,
  output logic [31:0] write_addr,
  output logic [31:0] write_data,
  output logic [3:0]  write_byteenable,
  output logic        write_writeenable,
  output logic [1:0]  state_out,
  output logic        full,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t         entries [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic              issuing;
  logic              pop;
  logic              store_req;
  logic              merge_hit;
  logic              merge_en;
  logic              alloc;
  logic [PW-1:0]     merge_idx;
  logic [PW-1:0]     slot;
  wb_entry_t         merged_entry;
  wb_entry_t         head_entry;
  wb_state_t         state;

  // Only the word address is compared; the low bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign issuing   = active && !empty;
  assign pop       = issuing && !waitrequest;
  assign store_req = write_en && (byteenable != 4'b0000);

  // Hit flag covers every valid entry, including the one on the bus.
  // The merge target is the youngest matching entry other than the
  // in-flight head: a store that arrives while the head is being written
  // allocates a fresh entry, and later stores to that word must land in
  // the newer copy so memory ends with the latest bytes.
  always_comb begin
    addr_in_wb = 1'b0;
    merge_hit  = 1'b0;
    merge_idx  = '0;
    slot       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].addr == addr[31:2])) begin
        addr_in_wb = 1'b1;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PW'(k);
      if (valid[slot] && (entries[slot].addr == addr[31:2]) &&
          !((k == 0) && issuing)) begin
        merge_hit = 1'b1;
        merge_idx = slot;
      end
    end
  end

  assign merge_en = store_req && merge_hit;
  assign alloc    = store_req && !merge_hit && !full;

  // Lane-by-lane overwrite of the merge target.
  always_comb begin
    merged_entry    = entries[merge_idx];
    merged_entry.be = entries[merge_idx].be | byteenable;
    for (int l = 0; l < 4; l++) begin
      if (byteenable[l]) begin
        merged_entry.data[8*l +: 8] = writedata[8*l +: 8];
      end
    end
  end

  // Entry payload needs no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (merge_en) begin
        entries[merge_idx] <= merged_entry;
      end else if (alloc) begin
        entries[tail] <= '{addr: addr[31:2], data: writedata, be: byteenable};
      end
    end
  end

  // Pointers, occupancy and valid bits. Allocation never targets the
  // popping slot: that would need head == tail with entries present,
  // which only happens when full, and full blocks allocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      case ({alloc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head outputs read zero while nothing is buffered.
  always_comb begin
    head_entry = '0;
    if (!empty) begin
      head_entry = entries[head];
    end
  end

  assign write_addr        = {head_entry.addr, 2'b00};
  assign write_data        = head_entry.data;
  assign write_byteenable  = head_entry.be;
  assign write_writeenable = issuing;

  always_comb begin
    state = WB_IDLE;
    if (issuing) begin
      state = WB_WRITE;
    end else if (!empty) begin
      state = WB_PENDING;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_mips_cache_write_buffer.sv
// Self-checking bench for mips_cache_write_buffer.
// A queue-based reference model predicts flags and the sequence of bus
// writes; a monitor process pops expected writes as the DUT issues them.
module tb_mips_cache_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        write_en = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        active = 1'b0;
  logic        waitrequest = 1'b0;
  logic        addr_in_wb;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [3:0]  write_byteenable;
  logic        write_writeenable;
  logic [1:0]  state_out;
  logic        full;
  logic        empty;

  always #5 clk = ~clk;

  mips_cache_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .addr              (addr),
    .write_en          (write_en),
    .writedata         (writedata),
    .byteenable        (byteenable),
    .active            (active),
    .waitrequest       (waitrequest),
    .addr_in_wb        (addr_in_wb),
    .write_addr        (write_addr),
    .write_data        (write_data),
    .write_byteenable  (write_byteenable),
    .write_writeenable (write_writeenable),
    .state_out         (state_out),
    .full              (full),
    .empty             (empty)
  );

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  ent_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   model_known = 1'b0;
  bit   hold_active = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] laneMask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int l = 0; l < 4; l++) if (be[l]) m[8*l +: 8] = 8'hFF;
    return m;
  endfunction

  // Reference behaviour for one clock edge, evaluated on pre-edge state.
  task automatic modelStep(input logic r, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be,
                           input logic act, input logic wr);
    bit   inflight;
    bit   merged;
    bit   do_alloc;
    int   pre_size;
    ent_t e;
    if (r) begin
      q.delete();
      hold_active = 1'b0;
      return;
    end
    pre_size = q.size();
    inflight = act && (pre_size > 0);
    merged   = 1'b0;
    do_alloc = 1'b0;
    if (we && (be != 4'b0000)) begin
      for (int i = pre_size - 1; i >= 0; i--) begin
        if (!merged && !(i == 0 && inflight) && q[i].a == a[31:2]) begin
          e = q[i];
          e.d  = (e.d & ~laneMask(be)) | (d & laneMask(be));
          e.be = e.be | be;
          q[i] = e;
          merged = 1'b1;
        end
      end
      if (!merged && pre_size < DEPTH) do_alloc = 1'b1;
    end
    if (inflight && !wr) begin
      exp_q.push_back(q[0]);
      void'(q.pop_front());
    end
    if (do_alloc) begin
      e.a = a[31:2]; e.d = d; e.be = be;
      q.push_back(e);
    end
    hold_active = inflight && wr;
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] be,
                               input logic act, input logic wr);
    int sz;
    bit exp_issue;
    bit exp_hit;
    logic [1:0] exp_state;
    @(negedge clk);
    rst = r; write_en = we; addr = a; writedata = d;
    byteenable = be; active = act; waitrequest = wr;
    #1;
    if (model_known) begin
      sz = q.size();
      exp_issue = act && (sz > 0);
      exp_hit = 1'b0;
      foreach (q[i]) if (q[i].a == a[31:2]) exp_hit = 1'b1;
      exp_state = (sz == 0) ? 2'd0 : (exp_issue ? 2'd1 : 2'd2);
      checkOutput("empty", 32'(empty), 32'(sz == 0));
      checkOutput("full", 32'(full), 32'(sz == DEPTH));
      checkOutput("write_en_bus", 32'(write_writeenable), 32'(exp_issue));
      checkOutput("state_out", 32'(state_out), 32'(exp_state));
      checkOutput("addr_in_wb", 32'(addr_in_wb), 32'(exp_hit));
      if (sz == 0)
        checkOutput("head_idle_zero", write_addr | write_data | {28'b0, write_byteenable}, 32'h0);
    end
    modelStep(r, we, a, d, be, act, wr);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; write_en = 1'b0; active = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    q.delete();
    exp_q.delete();
    hold_active = 1'b0;
    model_known = 1'b1;
  endtask

  // Monitor: every accepted bus write must match the oldest expected one.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (model_known && !rst && write_writeenable && !waitrequest) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("[TB] FAIL drain_unexpected: got write 0x%08h, expected no write at %0t", write_addr, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("drain_addr", write_addr, {e.a, 2'b00});
          checkOutput("drain_data", write_data, e.d);
          checkOutput("drain_be", {28'b0, write_byteenable}, {28'b0, e.be});
        end
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic        ract;
    doReset();
    $display("[TB] directed sequences");
    // Reset state and hit flag for an unbuffered address.
    applyStimulus(0, 0, 32'h100, 0, 4'b0000, 0, 0);
    // Enqueue, pend, stall twice, then pop.
    applyStimulus(0, 1, 32'h100, 32'hDEADBEEF, 4'b1111, 0, 0);
    applyStimulus(0, 0, 32'h100, 0, 4'b0000, 0, 0);
    applyStimulus(0, 0, 32'h100, 0, 4'b0000, 1, 1);
    applyStimulus(0, 0, 32'h100, 0, 4'b0000, 1, 1);
    applyStimulus(0, 0, 32'h100, 0, 4'b0000, 1, 0);
    applyStimulus(0, 0, 32'h100, 0, 4'b0000, 0, 0);
    // Merge two partial stores to one word, then drain.
    applyStimulus(0, 1, 32'h200, 32'h000000AA, 4'b0001, 0, 0);
    applyStimulus(0, 1, 32'h200, 32'hBB000000, 4'b1000, 0, 0);
    applyStimulus(0, 1, 32'h202, 32'h11223344, 4'b0000, 0, 0);
    applyStimulus(0, 0, 32'h200, 0, 4'b0000, 1, 0);
    // Fill, overflow attempt, partial drain, refill across the wrap.
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, 32'h400 + 32'(i * 4), 32'hA0 + 32'(i), 4'b1111, 0, 0);
    applyStimulus(0, 0, 32'h410, 0, 4'b0000, 1, 0);
    applyStimulus(0, 0, 32'h410, 0, 4'b0000, 1, 0);
    applyStimulus(0, 1, 32'h500, 32'h55, 4'b0011, 0, 0);
    applyStimulus(0, 1, 32'h504, 32'h66, 4'b1100, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 32'h0, 0, 4'b0000, 1, 0);
    // In-flight head is protected; a same-word store allocates a new entry.
    applyStimulus(0, 1, 32'h300, 32'h12345678, 4'b1111, 0, 0);
    applyStimulus(0, 1, 32'h300, 32'hCAFEF00D, 4'b0110, 1, 1);
    applyStimulus(0, 1, 32'h300, 32'h000000EE, 4'b0001, 1, 1);
    applyStimulus(0, 0, 32'h300, 0, 4'b0000, 1, 0);
    applyStimulus(0, 0, 32'h300, 0, 4'b0000, 1, 0);
    // Push and pop in the same cycle at count 2.
    applyStimulus(0, 1, 32'h600, 32'h1, 4'b1111, 0, 0);
    applyStimulus(0, 1, 32'h604, 32'h2, 4'b1111, 0, 0);
    applyStimulus(0, 1, 32'h608, 32'h3, 4'b1111, 1, 0);
    applyStimulus(0, 0, 32'h0, 0, 4'b0000, 1, 0);
    applyStimulus(0, 0, 32'h0, 0, 4'b0000, 1, 0);
    applyStimulus(0, 0, 32'h0, 0, 4'b0000, 0, 0);
    // Reset in the middle of a stalled drain discards everything.
    applyStimulus(0, 1, 32'h700, 32'h7, 4'b1111, 0, 0);
    applyStimulus(0, 1, 32'h704, 32'h8, 4'b1111, 1, 1);
    applyStimulus(1, 0, 32'h700, 0, 4'b0000, 1, 1);
    applyStimulus(0, 0, 32'h700, 0, 4'b0000, 0, 0);

    $display("[TB] randomized sequence");
    for (int n = 0; n < 400; n++) begin
      ra   = 32'h1000 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      ract = hold_active ? 1'b1 : ($urandom_range(0, 2) != 0);
      applyStimulus(0, 1'($urandom_range(0, 1)), ra, $urandom,
                    4'($urandom_range(0, 15)), ract, ($urandom_range(0, 2) == 0));
    end

    for (int i = 0; i < 40 && (q.size() > 0 || hold_active); i++)
      applyStimulus(0, 0, 32'h0, 0, 4'b0000, 1, 0);
    applyStimulus(0, 0, 32'h0, 0, 4'b0000, 0, 0);
    @(negedge clk);
    #3;
    checkOutput("scoreboard_left", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_cache_write_buffer.md
Name: mips_cache_write_buffer

Overview:
- Posted-write FIFO between the MIPS data port and the Avalon memory bus; sits inside the cache controller beside the instruction and data caches.
- Accepts CPU stores immediately and combines stores to the same word.
- Drains entries to the bus only while the controller grants `active`.
- Reports full/empty, drain status and an address-hit flag so the controller can keep memory coherent.

Parameters:
- DEPTH, 4, number of word entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- addr  in  32  CPU data address; word compare on [31:2]
- write_en  in  1  CPU store request
- writedata  in  32  store data
- byteenable  in  4  store byte lanes
- active  in  1  controller grants bus for draining
- waitrequest  in  1  Avalon waitrequest
- addr_in_wb  out  1  addr word matches a valid entry
- write_addr  out  32  head entry address, {addr[31:2],2'b00}
- write_data  out  32  head entry data
- write_byteenable  out  4  head entry byte lanes
- write_writeenable  out  1  Avalon write
- state_out  out  2  drain status
- full  out  1  count==DEPTH
- empty  out  1  count==0

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Reset clears all valid bits and sets head = tail = count = 0, so empty=1, full=0, write_writeenable=0, state_out=0.
  - Head outputs drive 0 while empty.
  - Reset mid-drain discards all entries.
- Storage: circular buffer with head/tail pointers that wrap modulo DEPTH. Each entry holds word address [31:2], 32-bit data and 4-bit byteenable.
- Enqueue (on the clk edge, when write_en=1 and byteenable!=0):
  - Merge case: addr[31:2] matches a valid entry that is not the in-flight head. Overwrite the selected bytes lane by lane (lane i = writedata[8i+7:8i] if byteenable[i]) and OR in the byteenable. Count is unchanged.
  - Allocate case: no eligible match and not full. Write a new entry at tail; tail+1, count+1.
  - Full and no match: request ignored. Upstream holds the store because the controller stalls the CPU on full.
  - Repeated identical write_en while the CPU is stalled merges idempotently, so no duplicate entries appear.
- In-flight head: the head entry while write_writeenable=1. It is never modified.
- Drain:
  - write_writeenable = active && !empty (combinational). Head fields drive write_addr, write_data and write_byteenable.
  - Pop at the edge where write_writeenable && !waitrequest: head+1, count-1.
  - Back-to-back drain continues while active stays high; next entry is presented the following cycle.
  - The controller never drops active while waitrequest=1 during a write.
- Simultaneous push and pop: count is unchanged; full is evaluated from the count at the start of the cycle.
- addr_in_wb: combinational, high when addr[31:2] equals any valid entry, the in-flight head included. Independent of write_en.
- state_out (combinational):
  - 2'd0 IDLE: empty.
  - 2'd1 WRITE: write_writeenable=1.
  - 2'd2 PENDING: entries present, active=0.
  - 2'd3 unused.
- full and empty are combinational from count.

Decomposition:
- Shared package mips_cache_pkg holds:
  - wb_state_t enum {WB_IDLE=0, WB_WRITE=1, WB_PENDING=2};
  - wb_entry_t struct {addr[29:0], data[31:0], be[3:0]};
  - DEFAULT_WB_DEPTH=4.
- Single module, no sub-module; the match/merge logic is an inline loop over entries.

Test Plan:
- Reset: assert rst 2 cycles → empty=1, full=0, write_writeenable=0, state_out=0, addr_in_wb=0 for addr=0x100.
- Enqueue then drain: store 0x100/0xDEADBEEF/1111 with active=0 → state_out=2, addr_in_wb=1. Raise active with waitrequest high 2 cycles → write_writeenable=1 and outputs stable 0x100/0xDEADBEEF/1111 across stall. Pop on waitrequest low → empty=1.
- Merge: store 0x200 data 0x000000AA be 0001, then 0x200 data 0xBB000000 be 1000 → single entry, count=1, write_data=0xBB0000AA, write_byteenable=1001.
- Full/wrap: 4 distinct stores → full=1. Fifth to a new address is ignored. Drain 2, enqueue 2 more → FIFO order preserved across pointer wrap.
- In-flight protection: head 0x300 issuing with waitrequest=1, store 0x300 arrives → head unchanged, new tail entry allocated, count=2.
- Push+pop same cycle at count=2 → count stays 2, next head presented the following cycle.
